// File: rtl/shift_rows_pipe.sv
// rtl/shift_rows_pipe.sv - AES-style ShiftRows / InvShiftRows with a two-entry
// registered skid buffer on the output side.
module shift_rows_pipe #(
  parameter int NB      = 4,
  parameter int ST_WORD = 8,
  parameter int CNT_W   = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [4*NB*ST_WORD-1:0] in_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NB*ST_WORD-1:0] out_data,
  output logic [1:0]              out_mode,
  output logic [CNT_W-1:0]        beat_cnt,
  output logic                    mode_err
);

  localparam int W = 4 * NB * ST_WORD;

  if (!(NB == 4 || NB == 6 || NB == 8)) begin : g_nb_check
    $error("shift_rows_pipe: NB must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {
    S_EMPTY = 2'b00,
    S_ONE   = 2'b01,
    S_FULL  = 2'b10
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0] main_data, skid_data, shifted;
  logic [1:0]   main_mode, skid_mode;
  logic         xfer_in, xfer_out;
  logic         load_main_in, load_skid, load_main_skid;

  // Rijndael row offsets: wide (NB=8) blocks skip offset 2 on rows 2 and 3.
  function automatic int row_off(input int l);
    if (NB == 8 && l >= 2) return l + 1;
    return l;
  endfunction

  // Byte (row l, column c) sits at byte index 4*c+l counted from the MSB.
  function automatic logic [W-1:0] shift_state(input logic [W-1:0] d,
                                               input logic [1:0] mode);
    logic [W-1:0] r;
    int           src;
    r = d;
    for (int l = 0; l < 4; l++) begin
      for (int c = 0; c < NB; c++) begin
        case (mode)
          2'b00:   src = (c + row_off(l)) % NB;
          2'b01:   src = (c + NB - row_off(l)) % NB;
          default: src = c;
        endcase
        r[ST_WORD*((NB-c)*4-l)-1 -: ST_WORD] = d[ST_WORD*((NB-src)*4-l)-1 -: ST_WORD];
      end
    end
    return r;
  endfunction

  assign shifted   = shift_state(in_data, in_mode);
  assign out_valid = (state != S_EMPTY);
  assign out_data  = main_data;
  assign out_mode  = main_mode;
  assign xfer_in   = in_valid & in_ready;
  assign xfer_out  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_skid      = 1'b0;
    load_main_skid = 1'b0;
    case (state)
      S_EMPTY: begin
        if (xfer_in) begin
          state_nxt    = S_ONE;
          load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (xfer_in && xfer_out) begin
          load_main_in = 1'b1;
        end else if (xfer_in) begin
          state_nxt = S_FULL;
          load_skid = 1'b1;
        end else if (xfer_out) begin
          state_nxt = S_EMPTY;
        end
      end
      S_FULL: begin
        if (xfer_out) begin
          state_nxt      = S_ONE;
          load_main_skid = 1'b1;
        end
      end
      default: state_nxt = S_EMPTY;
    endcase
  end

  // Registered ready looks one state ahead so it drops exactly when FULL is entered.
  always_ff @(posedge clk) begin
    if (rst) in_ready <= 1'b0;
    else     in_ready <= (state_nxt != S_FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_data <= '0;
      main_mode <= 2'b00;
      skid_data <= '0;
      skid_mode <= 2'b00;
    end else begin
      if (load_main_in) begin
        main_data <= shifted;
        main_mode <= in_mode;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_mode <= skid_mode;
      end
      if (load_skid) begin
        skid_data <= shifted;
        skid_mode <= in_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
      mode_err <= 1'b0;
    end else begin
      if (xfer_out && beat_cnt != {CNT_W{1'b1}}) beat_cnt <= beat_cnt + 1'b1;
      if (xfer_in && in_mode == 2'b11) mode_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_shift_rows_pipe.sv
// tb/tb_shift_rows_pipe.sv - directed checks of shift_rows_pipe for NB=4 and
// NB=8 (small beat counter for saturation).
module tb_shift_rows_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_mode_err;
  logic [127:0] a_in_data, a_out_data;
  logic [1:0]   a_in_mode, a_out_mode;
  logic [15:0]  a_beat_cnt;

  logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_mode_err;
  logic [255:0] b_in_data, b_out_data;
  logic [1:0]   b_in_mode, b_out_mode;
  logic [1:0]   b_beat_cnt;

  shift_rows_pipe #(.NB(4), .ST_WORD(8), .CNT_W(16)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data), .out_mode(a_out_mode),
    .beat_cnt(a_beat_cnt), .mode_err(a_mode_err)
  );

  shift_rows_pipe #(.NB(8), .ST_WORD(8), .CNT_W(2)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data), .out_mode(b_out_mode),
    .beat_cnt(b_beat_cnt), .mode_err(b_mode_err)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] VEC_A = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] ENC_A = 128'h00050a0f04090e03080d02070c01060b;
  localparam logic [127:0] DEC_A = 128'h000d0a0704010e0b0805020f0c090603;

  logic [255:0] vec_b, enc_b;
  logic [7:0]   byte_b;

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = 2'b00; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = 2'b00; b_out_ready = 1'b0;
    for (int k = 0; k < 32; k++) vec_b[255-8*k -: 8] = 8'(k);

    step(); step();
    @(negedge clk);
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_in_ready", a_in_ready, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_mode", a_out_mode, 0);
    chk("rst_beat_cnt", a_beat_cnt, 0);
    chk("rst_mode_err", a_mode_err, 0);

    step(); rst = 1'b0;
    step();
    @(negedge clk);
    chk("ready_after_rst", a_in_ready, 1);

    // enc, dec, round trip, bypass - one beat at a time
    step(); a_in_valid = 1'b1; a_in_data = VEC_A; a_in_mode = 2'b00; a_out_ready = 1'b1;
    step(); a_in_valid = 1'b0;
    @(negedge clk);
    chk("enc_valid", a_out_valid, 1);
    chk("enc_data", a_out_data, ENC_A);
    chk("enc_mode", a_out_mode, 2'b00);
    step();
    @(negedge clk);
    chk("enc_cnt", a_beat_cnt, 1);
    chk("enc_drained", a_out_valid, 0);

    a_in_valid = 1'b1; a_in_data = VEC_A; a_in_mode = 2'b01;
    step(); a_in_valid = 1'b0;
    @(negedge clk);
    chk("dec_data", a_out_data, DEC_A);
    chk("dec_mode", a_out_mode, 2'b01);

    a_in_valid = 1'b1; a_in_data = ENC_A; a_in_mode = 2'b01;
    step(); a_in_valid = 1'b0;
    @(negedge clk);
    chk("roundtrip4", a_out_data, VEC_A);

    a_in_valid = 1'b1; a_in_data = VEC_A; a_in_mode = 2'b10;
    step(); a_in_valid = 1'b0;
    @(negedge clk);
    chk("bypass_data", a_out_data, VEC_A);
    chk("bypass_mode", a_out_mode, 2'b10);
    step();
    @(negedge clk);
    chk("cnt_4", a_beat_cnt, 4);

    // backpressure: three beats offered, two accepted
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_mode = 2'b10; a_in_data = 128'h11;
    step(); a_in_data = 128'h22;
    step(); a_in_data = 128'h33;
    @(negedge clk);
    chk("bp_full_ready", a_in_ready, 0);
    chk("bp_head", a_out_data, 128'h11);
    step();
    @(negedge clk);
    chk("bp_hold_valid", a_out_valid, 1);
    chk("bp_hold_data", a_out_data, 128'h11);
    chk("bp_hold_cnt", a_beat_cnt, 4);
    a_out_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_second", a_out_data, 128'h22);
    chk("bp_cnt", a_beat_cnt, 5);
    chk("bp_ready_back", a_in_ready, 1);
    step(); a_in_valid = 1'b0;
    @(negedge clk);
    chk("bp_third", a_out_data, 128'h33);
    chk("bp_cnt2", a_beat_cnt, 6);
    step();
    @(negedge clk);
    chk("bp_drained", a_out_valid, 0);
    chk("bp_cnt3", a_beat_cnt, 7);

    // reserved mode
    a_in_valid = 1'b1; a_in_data = VEC_A; a_in_mode = 2'b11;
    step(); a_in_valid = 1'b0; a_in_mode = 2'b00;
    @(negedge clk);
    chk("rsv_data", a_out_data, VEC_A);
    chk("rsv_mode", a_out_mode, 2'b11);
    chk("rsv_err", a_mode_err, 1);
    step(); step();
    @(negedge clk);
    chk("rsv_err_sticky", a_mode_err, 1);

    // full throughput
    a_in_valid = 1'b1; a_in_mode = 2'b10; a_in_data = 128'h100;
    for (int k = 0; k < 4; k++) begin
      step();
      a_in_data = 128'h100 + 128'(k + 1);
      if (k == 3) a_in_valid = 1'b0;
      @(negedge clk);
      chk("tput_data", a_out_data, 128'h100 + 128'(k));
      chk("tput_ready", a_in_ready, 1);
    end
    step();

    // reset while FULL
    a_out_ready = 1'b0;
    a_in_valid = 1'b1; a_in_data = 128'h55;
    step(); step(); a_in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_full", a_in_ready, 0);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_valid", a_out_valid, 0);
    chk("midrst_cnt", a_beat_cnt, 0);
    chk("midrst_err", a_mode_err, 0);
    chk("midrst_ready", a_in_ready, 0);
    rst = 1'b0;
    step();
    @(negedge clk);
    chk("postrst_ready", a_in_ready, 1);
    chk("postrst_valid", a_out_valid, 0);

    // NB=8: offsets 0,1,3,4 and round trip
    b_out_ready = 1'b1;
    b_in_valid = 1'b1; b_in_data = vec_b; b_in_mode = 2'b00;
    step(); b_in_valid = 1'b0;
    @(negedge clk);
    enc_b = b_out_data;
    byte_b = enc_b[255-8*1 -: 8]; chk("nb8_r1c0", byte_b, 8'h05);
    byte_b = enc_b[255-8*2 -: 8]; chk("nb8_r2c0", byte_b, 8'h0e);
    byte_b = enc_b[255-8*3 -: 8]; chk("nb8_r3c0", byte_b, 8'h13);
    byte_b = enc_b[255-8*31 -: 8]; chk("nb8_r3c7", byte_b, 8'h0f);
    b_in_valid = 1'b1; b_in_data = enc_b; b_in_mode = 2'b01;
    step(); b_in_valid = 1'b0;
    @(negedge clk);
    chk("nb8_roundtrip", b_out_data, vec_b);
    b_in_valid = 1'b1; b_in_mode = 2'b10;
    step(); step(); step(); b_in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("nb8_cnt_sat", b_beat_cnt, 2'b11);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
